smc_mac_lite18: RTL and testbench
=================================

Name: smc_mac_lite18

Overview:
Memory access controller (MAC) stage directly downstream of the SMC AHB-lite interface. It accepts one AHB access per new_access18 strobe and splits it into 1, 2 or 4 byte-wide beats on an 8-bit external static-memory bus. Each beat is sequenced through setup, strobe (with programmable wait states) and hold phases. The block returns smc_idle18, smc_done18, mac_done18 and the assembled read_data18 to the interface stage.

Parameters:
ADDR_W, 16, width of external address bus smc_addr18 (1..32)
WAIT_CYC, 2, extra strobe cycles per beat (0..15); strobe phase lasts WAIT_CYC+1 cycles

Ports:
hclk18  input  1  system clock, all flops on rising edge
n_sys_reset18  input  1  asynchronous active-low reset
new_access18  input  1  valid AHB access in address phase this cycle
cs  input  1  chip select from interface stage
addr  input  32  AHB byte address (address phase)
xfer_size18  input  2  00 byte, 01 half, 10 word, 11 treated as word
n_read18  input  1  0 read, 1 write (address phase)
write_data18  input  32  AHB write data (data phase, cycle after new_access18)
smc_idle18  output  1  high in IDLE
smc_done18  output  1  high for the single HOLD cycle of each beat
mac_done18  output  1  high throughout the last beat of an access
read_data18  output  32  assembled read data
smc_addr18  output  ADDR_W  external byte address
smc_data_out18  output  8  external write byte
smc_data_in18  input  8  external read byte
smc_data_oe18  output  1  pad output enable, high while driving a write byte
smc_n_cs18  output  1  external chip select, active low
smc_n_oe18  output  1  external output enable, active low
smc_n_we18  output  1  external write enable, active low

Behaviour:
- Reset, asynchronous and immediate, including mid-access: FSM returns to IDLE; smc_idle18=1; smc_done18=0; mac_done18=0; read_data18=0; smc_addr18=0; smc_data_out18=0; smc_data_oe18=0; smc_n_cs18=1; smc_n_oe18=1; smc_n_we18=1.
- FSM states: IDLE, SETUP, STROBE, HOLD (and TURN if the optional feature is compiled in).
- IDLE: on new_access18&cs, latch addr, xfer_size18 and n_read18; set beat count N (1/2/4) and beat index k=0; go to SETUP. Otherwise stay in IDLE.
- SETUP, 1 cycle: smc_n_cs18=0; smc_addr18 = (latched addr + k) truncated to ADDR_W bits. For a write, smc_data_oe18=1. On the first SETUP of an access (k=0), capture write_data18. For a read at k=0, clear read_data18 to 0. Next state STROBE.
- STROBE, WAIT_CYC+1 cycles (wait counter): smc_n_cs18=0. A read drives smc_n_oe18=0; a write drives smc_n_we18=0 and smc_data_out18 = captured data byte at lane L = (addr[1:0]+k) mod 4. For a read, sample smc_data_in18 into read_data18[8L+7:8L] on the last STROBE cycle. Other lanes are untouched. Next state HOLD.
- HOLD, 1 cycle: smc_n_cs18=0; strobes inactive; write data still driven; smc_done18=1.
  - If k<N-1: k++, go to SETUP.
  - Else: go to IDLE, or straight to SETUP of a new access if new_access18&cs in this cycle. Latch the new access exactly as in IDLE.
- mac_done18 = 1 when k==N-1 in SETUP, STROBE or HOLD. So smc_done18&mac_done18 is a single-cycle pulse at the end of the access.
- read_data18 holds its value until the next read access starts; it is valid when smc_done18&mac_done18 is high.
- new_access18 outside IDLE and the last HOLD cycle is ignored (cannot occur while smc_hready18 is low).
- Access latency in cycles = N*(WAIT_CYC+3).
- Misaligned accesses are blocked upstream. The lane computation wraps mod 4 and the address increment wraps at ADDR_W.

Optional Feature:
SMC_TURNAROUND_EN
- Defined: after the final HOLD of a read access, enter TURN for 1 cycle. TURN drives all strobes inactive, smc_n_cs18=1 and smc_idle18=0, then returns to IDLE. new_access18 in the last-HOLD cycle is still latched, and SETUP starts after TURN.
- Undefined: no TURN state, and back-to-back accesses proceed as described above.

Test Plan:
- Reset mid-STROBE of a word write: n_sys_reset18 low. All outputs return to reset values without a clock edge; smc_idle18=1.
- Byte read, addr=0x0000_0102, WAIT_CYC=2, smc_data_in18=0xA5: one beat of 5 cycles with smc_addr18=0x0102. read_data18=0x00A5_0000; smc_done18&mac_done18 high in cycle 5.
- Word write, addr=0x10, write_data18=0x44332211: 4 beats at 0x10..0x13 with bytes 11,22,33,44. smc_n_we18 is low for 3 cycles per beat, total 20 cycles; mac_done18 is high only in beat 4.
- Half read at addr=0x2 with input bytes 0x5A then 0xC3: read_data18=0xC35A_0000, and lanes 0-1 read 0.
- Back-to-back: new_access18 during the last HOLD of a write. The next SETUP follows immediately with no IDLE cycle; with SMC_TURNAROUND_EN after a read, exactly one TURN cycle is inserted.
- Address wrap, ADDR_W=16, word at 0x0000_FFFC: smc_addr18 steps through FFFC, FFFD, FFFE, FFFF; lanes 0-3 are accessed in order.

Source files
------------

// File: rtl/smc_mac_lite18_if.sv
// Bus bundle between the SMC AHB-lite interface stage, the MAC stage and the
// external 8-bit static-memory pins. The slave modport is the MAC's view.
interface smc_mac_lite18_if #(
  parameter int ADDR_W = 16
);
  // Interface-stage side
  logic              new_access18;
  logic              cs;
  logic [31:0]       addr;
  logic [1:0]        xfer_size18;
  logic              n_read18;
  logic [31:0]       write_data18;
  logic              smc_idle18;
  logic              smc_done18;
  logic              mac_done18;
  logic [31:0]       read_data18;

  // External memory side
  logic [ADDR_W-1:0] smc_addr18;
  logic [7:0]        smc_data_out18;
  logic [7:0]        smc_data_in18;
  logic              smc_data_oe18;
  logic              smc_n_cs18;
  logic              smc_n_oe18;
  logic              smc_n_we18;

  modport master (
    output new_access18, cs, addr, xfer_size18, n_read18, write_data18,
    output smc_data_in18,
    input  smc_idle18, smc_done18, mac_done18, read_data18,
    input  smc_addr18, smc_data_out18, smc_data_oe18,
    input  smc_n_cs18, smc_n_oe18, smc_n_we18
  );

  modport slave (
    input  new_access18, cs, addr, xfer_size18, n_read18, write_data18,
    input  smc_data_in18,
    output smc_idle18, smc_done18, mac_done18, read_data18,
    output smc_addr18, smc_data_out18, smc_data_oe18,
    output smc_n_cs18, smc_n_oe18, smc_n_we18
  );
endinterface

// File: rtl/smc_mac_lite18.sv
// SMC memory access controller: splits one AHB access into 1/2/4 byte beats,
// each SETUP -> STROBE (WAIT_CYC+1) -> HOLD. Optional SMC_TURNAROUND_EN adds a TURN cycle after reads.
module smc_mac_lite18 #(
  parameter int ADDR_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input logic              hclk18,
  input logic              n_sys_reset18,
  smc_mac_lite18_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_TURN
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  state_t            state;
  logic [1:0]        beat;        // k
  logic [1:0]        last_beat;   // N-1
  logic [1:0]        lane_base;   // addr[1:0] of the access
  logic [ADDR_W-1:0] addr_lat;
  logic              is_write;
  logic [3:0]        wait_cnt;
  logic [31:0]       wdata;
  logic              capture_wd;  // data phase of a just-accepted access
`ifdef SMC_TURNAROUND_EN
  logic              pending;     // access accepted during a read's last HOLD
`endif

  logic              idle_q;
  logic              done_q;
  logic              mac_done_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] saddr_q;
  logic [7:0]        dout_q;
  logic              doe_q;
  logic              n_cs_q;
  logic              n_oe_q;
  logic              n_we_q;

  logic              accept;
  logic              last;
  logic              take;
  logic              turn_hold;
  logic              take_now;
  logic [1:0]        acc_last;
  logic [1:0]        beat_nxt;
  logic [1:0]        lane;
  logic [31:0]       wd_src;
  logic [7:0]        wd_byte;
  logic [ADDR_W-1:0] addr_nxt;
  logic              unused_addr;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    acc_last = 2'd3;
    case (bus.xfer_size18)
      2'b00:   acc_last = 2'd0;
      2'b01:   acc_last = 2'd1;
      default: acc_last = 2'd3;
    endcase
  end

  assign accept   = bus.new_access18 & bus.cs;
  assign last     = (beat == last_beat);
  assign take     = accept && ((state == S_IDLE) || ((state == S_HOLD) && last));
`ifdef SMC_TURNAROUND_EN
  assign turn_hold = (state == S_HOLD) && last && !is_write;
`else
  assign turn_hold = 1'b0;
`endif
  assign take_now = take && !turn_hold;
  assign beat_nxt = beat + 2'd1;
  assign lane     = lane_base + beat;
  // Write data arrives one cycle after acceptance; bypass the register on that cycle.
  assign wd_src   = capture_wd ? bus.write_data18 : wdata;
  assign wd_byte  = 8'(wd_src >> {lane, 3'b000});
  assign addr_nxt = addr_lat + ADDR_W'(beat_nxt);
  assign unused_addr = ^bus.addr;

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge hclk18 or negedge n_sys_reset18) begin
    if (!n_sys_reset18) begin
      state      <= S_IDLE;
      beat       <= 2'd0;
      last_beat  <= 2'd0;
      lane_base  <= 2'd0;
      addr_lat   <= '0;
      is_write   <= 1'b0;
      wait_cnt   <= 4'd0;
      wdata      <= 32'd0;
      capture_wd <= 1'b0;
`ifdef SMC_TURNAROUND_EN
      pending    <= 1'b0;
`endif
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
      mac_done_q <= 1'b0;
      rdata_q    <= 32'd0;
      saddr_q    <= '0;
      dout_q     <= 8'd0;
      doe_q      <= 1'b0;
      n_cs_q     <= 1'b1;
      n_oe_q     <= 1'b1;
      n_we_q     <= 1'b1;
    end else begin
      capture_wd <= take;
      if (capture_wd) wdata <= bus.write_data18;

      if (take) begin
        addr_lat  <= bus.addr[ADDR_W-1:0];
        lane_base <= bus.addr[1:0];
        is_write  <= bus.n_read18;
        last_beat <= acc_last;
        beat      <= 2'd0;
      end

      if (take_now) begin
        state      <= S_SETUP;
        idle_q     <= 1'b0;
        done_q     <= 1'b0;
        n_cs_q     <= 1'b0;
        saddr_q    <= bus.addr[ADDR_W-1:0];
        doe_q      <= bus.n_read18;
        mac_done_q <= (acc_last == 2'd0);
        if (!bus.n_read18) rdata_q <= 32'd0;
      end else begin
        case (state)
          S_IDLE: begin
          end

          S_SETUP: begin
            state    <= S_STROBE;
            wait_cnt <= WAIT_INIT;
            n_oe_q   <= is_write;
            n_we_q   <= !is_write;
            if (is_write) dout_q <= wd_byte;
          end

          S_STROBE: begin
            if (wait_cnt == 4'd0) begin
              state  <= S_HOLD;
              n_oe_q <= 1'b1;
              n_we_q <= 1'b1;
              done_q <= 1'b1;
              if (!is_write) rdata_q[{lane, 3'b000} +: 8] <= bus.smc_data_in18;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end

          S_HOLD: begin
            done_q <= 1'b0;
            if (!last) begin
              state      <= S_SETUP;
              beat       <= beat_nxt;
              saddr_q    <= addr_nxt;
              mac_done_q <= (beat_nxt == last_beat);
            end else if (turn_hold) begin
              state      <= S_TURN;
              n_cs_q     <= 1'b1;
              doe_q      <= 1'b0;
              mac_done_q <= 1'b0;
`ifdef SMC_TURNAROUND_EN
              pending    <= take;
`endif
            end else begin
              state      <= S_IDLE;
              idle_q     <= 1'b1;
              n_cs_q     <= 1'b1;
              doe_q      <= 1'b0;
              mac_done_q <= 1'b0;
            end
          end

`ifdef SMC_TURNAROUND_EN
          S_TURN: begin
            pending <= 1'b0;
            if (pending) begin
              state      <= S_SETUP;
              n_cs_q     <= 1'b0;
              saddr_q    <= addr_lat;
              doe_q      <= is_write;
              mac_done_q <= (last_beat == 2'd0);
              if (!is_write) rdata_q <= 32'd0;
            end else begin
              state  <= S_IDLE;
              idle_q <= 1'b1;
            end
          end
`endif

          default: begin
            state  <= S_IDLE;
            idle_q <= 1'b1;
            n_cs_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.smc_idle18     = idle_q;
  assign bus.smc_done18     = done_q;
  assign bus.mac_done18     = mac_done_q;
  assign bus.read_data18    = rdata_q;
  assign bus.smc_addr18     = saddr_q;
  assign bus.smc_data_out18 = dout_q;
  assign bus.smc_data_oe18  = doe_q;
  assign bus.smc_n_cs18     = n_cs_q;
  assign bus.smc_n_oe18     = n_oe_q;
  assign bus.smc_n_we18     = n_we_q;

endmodule

// File: tb/tb_smc_mac_lite18.sv
// Directed self-checking bench for smc_mac_lite18 (ADDR_W=16, WAIT_CYC=2);
// follows SMC_TURNAROUND_EN when it is defined for the build.
module tb_smc_mac_lite18;

  localparam int ADDR_W   = 16;
  localparam int WAIT_CYC = 2;
  localparam int BEAT_CYC = WAIT_CYC + 3;
`ifdef SMC_TURNAROUND_EN
  localparam logic TURN_EXP = 1'b1;
`else
  localparam logic TURN_EXP = 1'b0;
`endif

  logic hclk18 = 1'b0;
  logic n_sys_reset18 = 1'b0;
  always #5 hclk18 = ~hclk18;

  smc_mac_lite18_if #(.ADDR_W(ADDR_W)) bus ();

  smc_mac_lite18 #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .hclk18        (hclk18),
    .n_sys_reset18 (n_sys_reset18),
    .bus           (bus)
  );

  // External memory model
  logic [7:0] mem [0:65535];
  always_comb bus.smc_data_in18 = mem[bus.smc_addr18];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Runs one access; returns at the negedge inside its final HOLD cycle.
  // b2b: issue the request in the current cycle (caller is in a final HOLD).
  task automatic do_access(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic rd, input logic [31:0] wd,
                           input logic b2b, input logic exp_turn);
    int beats, cyc, done_seen, we_cnt, oe_cnt, md_cnt, md_bad, wait_n;
    logic finished;
    logic [31:0] exp_rd;
    logic [1:0] lane;
    logic [ADDR_W-1:0] ea;
    logic [7:0] exp_byte;

    beats = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_rd = 32'd0;
    for (int b = 0; b < beats; b++) begin
      lane = a[1:0] + 2'(b);
      ea   = a[ADDR_W-1:0] + ADDR_W'(b);
      exp_rd[{lane, 3'b000} +: 8] = mem[ea];
    end

    if (!b2b) begin
      wait_n = 0;
      @(negedge hclk18);
      while (!bus.smc_idle18 && wait_n < 20) begin
        @(negedge hclk18);
        wait_n++;
      end
      check({tag, " idle before start"}, {31'd0, bus.smc_idle18}, 32'd1);
    end

    bus.new_access18 = 1'b1;
    bus.cs           = 1'b1;
    bus.addr         = a;
    bus.xfer_size18  = sz;
    bus.n_read18     = ~rd;
    bus.write_data18 = 32'hDEAD_BEEF;
    @(negedge hclk18);
    bus.new_access18 = 1'b0;
    bus.cs           = 1'b0;
    bus.addr         = 32'hFFFF_FFFF;
    bus.write_data18 = wd;

    if (exp_turn) begin
      check({tag, " turn n_cs"}, {31'd0, bus.smc_n_cs18}, 32'd1);
      check({tag, " turn idle"}, {31'd0, bus.smc_idle18}, 32'd0);
      @(negedge hclk18);
    end

    check({tag, " setup n_cs"}, {31'd0, bus.smc_n_cs18}, 32'd0);
    check({tag, " setup idle"}, {31'd0, bus.smc_idle18}, 32'd0);

    cyc = 0; done_seen = 0; we_cnt = 0; oe_cnt = 0; md_cnt = 0; md_bad = 0;
    finished = 1'b0;
    while (!finished && cyc < 100) begin
      cyc++;
      if (cyc == 2) bus.write_data18 = 32'h0BAD_F00D;
      lane = a[1:0] + 2'(done_seen);
      ea   = a[ADDR_W-1:0] + ADDR_W'(done_seen);
      if (!bus.smc_n_cs18) begin
        check({tag, " smc_addr"}, 32'(bus.smc_addr18), 32'(ea));
        check({tag, " data_oe"}, {31'd0, bus.smc_data_oe18}, {31'd0, ~rd});
      end
      if (!bus.smc_n_we18) begin
        we_cnt++;
        exp_byte = 8'(wd >> {lane, 3'b000});
        check({tag, " write byte"}, 32'(bus.smc_data_out18), 32'(exp_byte));
      end
      if (!bus.smc_n_oe18) oe_cnt++;
      if (bus.mac_done18) begin
        md_cnt++;
        if (done_seen != beats - 1) md_bad++;
      end
      if (bus.smc_done18) begin
        done_seen++;
        if (bus.mac_done18) finished = 1'b1;
      end
      if (!finished) @(negedge hclk18);
    end

    check({tag, " latency"}, 32'(cyc), 32'(beats * BEAT_CYC));
    check({tag, " beats"}, 32'(done_seen), 32'(beats));
    check({tag, " active strobe cycles"}, 32'(rd ? oe_cnt : we_cnt), 32'(beats * (WAIT_CYC + 1)));
    check({tag, " idle strobe cycles"}, 32'(rd ? we_cnt : oe_cnt), 32'd0);
    check({tag, " mac_done cycles"}, 32'(md_cnt), 32'(BEAT_CYC));
    check({tag, " mac_done early"}, 32'(md_bad), 32'd0);
    if (rd) check({tag, " read_data"}, bus.read_data18, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h77;
    mem[16'h0102] = 8'hA5;
    mem[16'h0002] = 8'h5A;
    mem[16'h0003] = 8'hC3;
    mem[16'h0030] = 8'h3C;
    mem[16'hFFFC] = 8'h01;
    mem[16'hFFFD] = 8'h02;
    mem[16'hFFFE] = 8'h03;
    mem[16'hFFFF] = 8'h04;

    bus.new_access18 = 1'b0;
    bus.cs           = 1'b0;
    bus.addr         = 32'd0;
    bus.xfer_size18  = 2'b00;
    bus.n_read18     = 1'b0;
    bus.write_data18 = 32'd0;

    repeat (2) @(negedge hclk18);
    check("reset idle", {31'd0, bus.smc_idle18}, 32'd1);
    check("reset n_cs", {31'd0, bus.smc_n_cs18}, 32'd1);
    check("reset read_data", bus.read_data18, 32'd0);
    check("reset smc_addr", 32'(bus.smc_addr18), 32'd0);
    n_sys_reset18 = 1'b1;

    // Single-beat reads; the second must clear lane 0 left by the first
    do_access("rd_b100", 32'h0000_0100, 2'b00, 1'b1, 32'd0, 1'b0, 1'b0);
    do_access("rd_b102", 32'h0000_0102, 2'b00, 1'b1, 32'd0, 1'b0, 1'b0);
    check("rd_b102 value", bus.read_data18, 32'h00A5_0000);

    do_access("wr_w10", 32'h0000_0010, 2'b10, 1'b0, 32'h4433_2211, 1'b0, 1'b0);

    do_access("rd_h2", 32'h0000_0002, 2'b01, 1'b1, 32'd0, 1'b0, 1'b0);
    check("rd_h2 value", bus.read_data18, 32'hC35A_0000);

    // Address wrap at ADDR_W; size 11 behaves as word
    do_access("wr_wrap", 32'h0000_FFFC, 2'b11, 1'b0, 32'hDDCC_BBAA, 1'b0, 1'b0);
    do_access("rd_wrap", 32'h0000_FFFC, 2'b10, 1'b1, 32'd0, 1'b0, 1'b0);
    check("rd_wrap value", bus.read_data18, 32'h0403_0201);

    // Back-to-back: write -> read (no gap), read -> write (TURN only if compiled in)
    do_access("wr_b20", 32'h0000_0020, 2'b00, 1'b0, 32'h0000_00E7, 1'b0, 1'b0);
    do_access("rd_b30_b2b", 32'h0000_0030, 2'b00, 1'b1, 32'd0, 1'b1, 1'b0);
    check("rd_b30 value", bus.read_data18, 32'h0000_003C);
    do_access("wr_h42_b2b", 32'h0000_0042, 2'b01, 1'b0, 32'hBEEF_1234, 1'b1, TURN_EXP);
    check("rd_b30 data held", bus.read_data18, 32'h0000_003C);

    // Asynchronous reset in the middle of a word write's STROBE
    @(negedge hclk18);
    while (!bus.smc_idle18) @(negedge hclk18);
    bus.new_access18 = 1'b1;
    bus.cs           = 1'b1;
    bus.addr         = 32'h0000_0050;
    bus.xfer_size18  = 2'b10;
    bus.n_read18     = 1'b1;
    @(negedge hclk18);
    bus.new_access18 = 1'b0;
    bus.cs           = 1'b0;
    bus.write_data18 = 32'h9988_77FF;
    @(negedge hclk18);
    check("rst pre n_we", {31'd0, bus.smc_n_we18}, 32'd0);
    #2 n_sys_reset18 = 1'b0;
    #1;
    check("rst idle", {31'd0, bus.smc_idle18}, 32'd1);
    check("rst smc_done", {31'd0, bus.smc_done18}, 32'd0);
    check("rst mac_done", {31'd0, bus.mac_done18}, 32'd0);
    check("rst read_data", bus.read_data18, 32'd0);
    check("rst smc_addr", 32'(bus.smc_addr18), 32'd0);
    check("rst data_out", 32'(bus.smc_data_out18), 32'd0);
    check("rst data_oe", {31'd0, bus.smc_data_oe18}, 32'd0);
    check("rst n_cs", {31'd0, bus.smc_n_cs18}, 32'd1);
    check("rst n_oe", {31'd0, bus.smc_n_oe18}, 32'd1);
    check("rst n_we", {31'd0, bus.smc_n_we18}, 32'd1);
    @(negedge hclk18);
    n_sys_reset18 = 1'b1;
    repeat (3) @(negedge hclk18);
    check("post rst idle", {31'd0, bus.smc_idle18}, 32'd1);
    check("post rst n_cs", {31'd0, bus.smc_n_cs18}, 32'd1);

    // Controller resumes normally after the reset
    do_access("rd_b100_again", 32'h0000_0100, 2'b00, 1'b1, 32'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
